// File: rtl/xpb_pkg.sv
// Shared definitions for the xpb reduction sequencer.
//   DIGIT_W, WORD_W, NUM_DIGITS : default geometry of one reduction pass
//   DEF_LUT_LAT                 : default registered-LUT read latency
//   xpb_state_e                 : sequencer FSM state (exported on the debug port)
//   acc_w()                     : accumulator width that can never overflow
package xpb_pkg;

  localparam int DIGIT_W     = 5;
  localparam int WORD_W      = 1024;
  localparam int NUM_DIGITS  = 37;
  localparam int DEF_LUT_LAT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } xpb_state_e;

  // Summing num_digits residues of word_w bits each needs
  // clog2(num_digits+1) extra bits of headroom.
  function automatic int acc_w(input int word_w, input int num_digits);
    return word_w + $clog2(num_digits + 1);
  endfunction

endpackage

// File: rtl/xpb_ret_pipe.sv
// Return-valid tracker for a registered LUT.
// Every issue strobe enters a LAT-deep shift register; the tail bit marks the
// cycle on which the LUT read data for that issue is valid.
// Ports:
//   clk_i      clock
//   clr_i      synchronous clear (drops every in-flight return)
//   push_i     issue strobe
//   tail_o     LUT read data valid this cycle
//   pending_o  some return is still in flight behind the tail
module xpb_ret_pipe #(
  parameter int LAT = 1
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic push_i,
  output logic tail_o,
  output logic pending_o
);

  logic [LAT-1:0] vld_q;
  logic [LAT-1:0] vld_d;

  // A single-stage pipe has nothing behind its tail, so "pending" is
  // constant zero there; deeper pipes look at every non-tail stage.
  if (LAT == 1) begin : g_single
    assign vld_d     = push_i;
    assign pending_o = 1'b0;
  end else begin : g_multi
    assign vld_d     = {vld_q[LAT-2:0], push_i};
    assign pending_o = |vld_q[LAT-2:0];
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign tail_o = vld_q[LAT-1];

endmodule

// File: rtl/xpb_reduce_seq.sv
// xpb modular-reduction sequencer.
// Takes the upper digits of a wide product, issues them one per cycle to a
// shared registered LUT port (tagged with the digit position), and sums the
// returned residues into an accumulator wide enough never to overflow.
//
// Handshakes (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. in_valid/in_digits must stay stable until
// accepted; out_valid/out_sum stay stable until out_ready is seen.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_ready only while IDLE
//   in_digits           NUM_DIGITS packed digits, digit i at [DIGIT_W*i +: DIGIT_W]
//   lut_en              LUT issue strobe (one per digit)
//   lut_idx, lut_digit  digit position and value; both 0 while lut_en is low
//   lut_rdata           residue returned LUT_LAT cycles after lut_en
//   out_valid/out_ready output handshake
//   out_sum             accumulated residue sum
//   dbg_state           current FSM state
//
// Timing (accept on cycle T): issues on T+1..T+NUM_DIGITS, out_valid first
// high on T+NUM_DIGITS+LUT_LAT+1.
module xpb_reduce_seq #(
  parameter int NUM_DIGITS = xpb_pkg::NUM_DIGITS,
  parameter int DIGIT_W    = xpb_pkg::DIGIT_W,
  parameter int WORD_W     = xpb_pkg::WORD_W,
  parameter int LUT_LAT    = xpb_pkg::DEF_LUT_LAT,
  parameter int IDX_W      = $clog2(NUM_DIGITS),
  parameter int ACC_W      = xpb_pkg::acc_w(WORD_W, NUM_DIGITS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] in_digits,
  output logic                          lut_en,
  output logic [IDX_W-1:0]              lut_idx,
  output logic [DIGIT_W-1:0]            lut_digit,
  input  logic [WORD_W-1:0]             lut_rdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_W-1:0]              out_sum,
  output xpb_pkg::xpb_state_e           dbg_state
);

  import xpb_pkg::*;

  xpb_state_e state_q;
  xpb_state_e state_d;

  logic [NUM_DIGITS*DIGIT_W-1:0] digits_q;
  logic [NUM_DIGITS*DIGIT_W-1:0] digits_d;
  logic [IDX_W-1:0]              idx_q;
  logic [IDX_W-1:0]              idx_d;
  logic [ACC_W-1:0]              acc_q;
  logic [ACC_W-1:0]              acc_d;

  logic accept;
  logic issue;
  logic last_issue;
  logic ret_tail;
  logic ret_pending;

  assign last_issue = (idx_q == IDX_W'(NUM_DIGITS - 1));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake and issue outputs are masked by rst so that the reset cycle
  // itself already shows the idle/quiet interface.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    issue     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        issue = !rst;
        if (last_issue) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The tail return (if any) is added on this same edge, so only the
        // stages behind it have to be empty before the sum is complete.
        if (!ret_pending) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = !rst;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dbg_state = state_q;

  // ---------------------------------------------------------------------------
  // Return tracking
  // ---------------------------------------------------------------------------
  xpb_ret_pipe #(
    .LAT (LUT_LAT)
  ) u_ret_pipe (
    .clk_i     (clk),
    .clr_i     (rst),
    .push_i    (issue),
    .tail_o    (ret_tail),
    .pending_o (ret_pending)
  );

  // ---------------------------------------------------------------------------
  // Datapath: digit register, index counter, accumulator
  // ---------------------------------------------------------------------------
  // The digit register shifts down one digit per issue, so the digit being
  // issued is always the low slice; no wide index mux is needed.
  always_comb begin
    digits_d = digits_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    if (accept) begin
      digits_d = in_digits;
      idx_d    = '0;
      acc_d    = '0;
    end else begin
      if (issue) begin
        digits_d = digits_q >> DIGIT_W;
        idx_d    = idx_q + IDX_W'(1);
      end
      if (ret_tail) begin
        acc_d = acc_q + ACC_W'(lut_rdata);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
    end else begin
      digits_q <= digits_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
    end
  end

  assign lut_en    = issue;
  assign lut_idx   = issue ? idx_q : '0;
  assign lut_digit = issue ? digits_q[DIGIT_W-1:0] : '0;
  assign out_sum   = acc_q;

endmodule

// File: tb/tb_xpb_reduce_seq.sv
module tb_xpb_reduce_seq;
  import xpb_pkg::*;

  localparam int N    = NUM_DIGITS;
  localparam int DW   = DIGIT_W;
  localparam int WW   = WORD_W;
  localparam int IW   = $clog2(N);
  localparam int AW   = acc_w(WW, N);
  localparam int LAT1 = 1;
  localparam int LAT3 = 3;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- DUT (LAT 1)
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N*DW-1:0]   in_digits = '0;
  logic              lut_en;
  logic [IW-1:0]     lut_idx;
  logic [DW-1:0]     lut_digit;
  logic [WW-1:0]     lut_rdata = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [AW-1:0]     out_sum;
  xpb_state_e        dbg_state;

  xpb_reduce_seq #(.LUT_LAT(LAT1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_digits(in_digits), .lut_en(lut_en), .lut_idx(lut_idx),
    .lut_digit(lut_digit), .lut_rdata(lut_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------- DUT (LAT 3)
  logic              in_valid3 = 1'b0;
  logic              in_ready3;
  logic [N*DW-1:0]   in_digits3 = '0;
  logic              lut_en3;
  logic [IW-1:0]     lut_idx3;
  logic [DW-1:0]     lut_digit3;
  logic [WW-1:0]     lut_rdata3 = '0;
  logic              out_valid3;
  logic              out_ready3 = 1'b0;
  logic [AW-1:0]     out_sum3;
  xpb_state_e        dbg_state3;

  xpb_reduce_seq #(.LUT_LAT(LAT3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_digits(in_digits3), .lut_en(lut_en3), .lut_idx(lut_idx3),
    .lut_digit(lut_digit3), .lut_rdata(lut_rdata3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_sum(out_sum3), .dbg_state(dbg_state3)
  );

  // ---------------------------------------------------------------- LUT models
  function automatic logic [WW-1:0] lut_val(input int idx, input int d);
    return WW'((idx + 1) * d);
  endfunction

  // Registered LUT: data for an issue appears one cycle later; garbage when
  // nothing was issued so stray accumulation shows up. The LAT-3 build adds
  // two more register stages.
  always @(posedge clk) lut_rdata <= lut_en ? lut_val(int'(lut_idx), int'(lut_digit)) : WW'($urandom);

  logic [WW-1:0] l3_s0 = '0, l3_s1 = '0;
  always @(posedge clk) begin
    l3_s0      <= lut_en3 ? lut_val(int'(lut_idx3), int'(lut_digit3)) : WW'($urandom);
    l3_s1      <= l3_s0;
    lut_rdata3 <= l3_s1;
  end

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: sum over digit positions of (position+1)*digit.
  function automatic logic [AW-1:0] model_sum(input logic [N*DW-1:0] d);
    longint s = 0;
    for (int i = 0; i < N; i++) s += longint'(i + 1) * longint'(d[i*DW +: DW]);
    return AW'(s);
  endfunction

  logic [AW-1:0]   exp_q[$];
  bit              active = 1'b0;
  int              t_acc  = 0;
  logic [N*DW-1:0] m_digits = '0;
  int              en_cnt = 0;

  always @(negedge clk) if (lut_en) en_cnt++;

  // Per-cycle compare of the LAT-1 DUT against the timing/sum model.
  always @(negedge clk) begin
    int k;
    bit e_en, e_ov, was_active;
    if (rst) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_lut_en", lut_en, 0);
      chk("rst_out_valid", out_valid, 0);
      active = 1'b0;
      exp_q.delete();
    end else begin
      was_active = active;
      k    = cyc - t_acc - 1;
      e_en = active && (k >= 0) && (k < N);
      e_ov = active && ((cyc - t_acc) >= N + LAT1 + 1);
      chk("in_ready", in_ready, !active);
      chk("lut_en", lut_en, e_en);
      chk("lut_idx", AW'(lut_idx), e_en ? AW'(k) : '0);
      chk("lut_digit", AW'(lut_digit), e_en ? AW'(m_digits[k*DW +: DW]) : '0);
      chk("out_valid", out_valid, e_ov);
      if (e_ov) begin
        if (exp_q.size() == 0) begin
          chk("exp_q_nonempty", 0, 1);
        end else begin
          chk("out_sum", out_sum, exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            active = 1'b0;
          end
        end
      end
      if (in_valid && !was_active) begin
        active   = 1'b1;
        t_acc    = cyc;
        m_digits = in_digits;
        exp_q.push_back(model_sum(in_digits));
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  // All driver tasks start and end at #1 after a rising edge.
  task automatic send(input logic [N*DW-1:0] d, output int t);
    int n = 0;
    in_digits = d;
    in_valid  = 1'b1;
    t = -1;
    while (1) begin
      @(negedge clk);
      if (in_ready) begin
        t = cyc;
        break;
      end
      n++;
      if (n > 200) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic recv(input int hold, output logic [AW-1:0] sum, output int ovc);
    int n = 0;
    sum = '0;
    ovc = -1;
    while (1) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
      if (n > 300) begin
        chk("recv_timeout", 1, 0);
        break;
      end
    end
    sum = out_sum;
    ovc = cyc;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_digits = rand_digits();
      @(negedge clk);
      chk("hold_sum_stable", out_sum, sum);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
    end
    if (!out_ready) begin
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      out_ready = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [N*DW-1:0] rand_digits();
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'($urandom_range(0, 31));
    return r;
  endfunction

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [N*DW-1:0] d;
    logic [AW-1:0]   s;
    int              t, ovc, e0, n;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Pin the model against hand-computed values.
    d = '0; d[0 +: DW] = 5'd1;
    chk("model_d0", model_sum(d), 1);
    d = '0; d[36*DW +: DW] = 5'd31;
    chk("model_d36", model_sum(d), 1147);
    d = {(N*DW){1'b1}};
    chk("model_all31", model_sum(d), 21793);

    // Post-reset state.
    @(negedge clk);
    chk("reset_out_sum", out_sum, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_lut_en", lut_en, 0);
    chk("reset_state", AW'(dbg_state), AW'(IDLE));
    @(posedge clk); #1;

    // 1: all-zero digits.
    e0 = en_cnt;
    send('0, t);
    recv(0, s, ovc);
    chk("s1_sum", s, 0);
    chk("s1_latency", AW'(ovc - t), 39);
    chk("s1_pulses", AW'(en_cnt - e0), 37);

    // 2: single nonzero digit at each end.
    d = '0; d[0 +: DW] = 5'd1;
    send(d, t); recv(0, s, ovc);
    chk("s2_d0_sum", s, 1);
    d = '0; d[36*DW +: DW] = 5'd31;
    send(d, t); recv(0, s, ovc);
    chk("s2_d36_sum", s, 1147);

    // 3: all 31, output stalled 10 cycles with in_valid noise.
    send({(N*DW){1'b1}}, t);
    recv(10, s, ovc);
    chk("s3_sum", s, 21793);

    // 4: back-to-back with out_ready held high.
    out_ready = 1'b1;
    send(rand_digits(), t);
    recv(0, s, ovc);
    for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'(i % 32);
    send(d, t);
    recv(0, s, ovc);
    chk("s4_second_sum", s, 11272);
    out_ready = 1'b0;

    // 5: reset in the middle of a pass, at issue index 20.
    send(rand_digits(), t);
    n = 0;
    while (!(lut_en && lut_idx == IW'(20)) && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chk("s5_reached_k20", AW'(lut_idx), 20);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("s5_state_idle", AW'(dbg_state), AW'(IDLE));
    chk("s5_out_valid", out_valid, 0);
    chk("s5_lut_en", lut_en, 0);
    chk("s5_out_sum", out_sum, 0);
    @(posedge clk); #1;
    send({(N*DW){1'b1}}, t);
    recv(0, s, ovc);
    chk("s5_fresh_sum", s, 21793);

    // Randomized passes: random digits, random stalls, random ready preset.
    for (int p = 0; p < 8; p++) begin
      send(rand_digits(), t);
      if ($urandom_range(0, 1) == 1) begin
        out_ready = 1'b1;
        recv(0, s, ovc);
        out_ready = 1'b0;
      end else begin
        recv($urandom_range(0, 4), s, ovc);
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end

    // 6: LUT_LAT = 3 build.
    in_digits3 = {(N*DW){1'b1}};
    in_valid3  = 1'b1;
    n = 0; t = -1;
    while (1) begin
      @(negedge clk);
      if (in_ready3) begin t = cyc; break; end
      n++;
      if (n > 50) begin chk("s6_accept_timeout", 1, 0); break; end
    end
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    n = 0; ovc = -1;
    while (1) begin
      @(negedge clk);
      if (out_valid3) begin ovc = cyc; break; end
      n++;
      if (n > 200) begin chk("s6_out_timeout", 1, 0); break; end
    end
    chk("s6_sum", out_sum3, 21793);
    chk("s6_latency", AW'(ovc - t), 41);
    @(posedge clk); #1;
    out_ready3 = 1'b1;
    @(posedge clk); #1;
    out_ready3 = 1'b0;
    @(negedge clk);
    chk("s6_back_idle", in_ready3, 1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog act=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
